// File: rtl/ghr_checkpoint_if.sv
// Prediction/resolve handshake and history outputs of the GHR checkpoint controller.
// The master drives predictions and resolves; the slave (controller) returns histories and status.
interface ghr_checkpoint_if #(
    parameter int HIST_W = 8,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              pred_valid;
    logic              pred_taken;
    logic              pred_ready;
    logic              resolve_valid;
    logic              resolve_taken;
    logic              resolve_mispredict;
    logic [HIST_W-1:0] spec_ghr;
    logic [HIST_W-1:0] arch_ghr;
    logic [CNT_W-1:0]  inflight;
    logic              flush;
    logic              resolve_err;

    modport master (
        output pred_valid, pred_taken, resolve_valid, resolve_taken, resolve_mispredict,
        input  pred_ready, spec_ghr, arch_ghr, inflight, flush, resolve_err
    );

    modport slave (
        input  pred_valid, pred_taken, resolve_valid, resolve_taken, resolve_mispredict,
        output pred_ready, spec_ghr, arch_ghr, inflight, flush, resolve_err
    );
endinterface

// File: rtl/ghr_checkpoint_ctrl.sv
// Global history controller: speculative/architectural GHR with an in-order checkpoint
// queue; a mispredict restores from the oldest checkpoint and inserts a one-cycle bubble.
module ghr_checkpoint_ctrl #(
    parameter int HIST_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    ghr_checkpoint_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {ST_RUN, ST_RECOVER} state_t;

    state_t            state_q, state_d;
    logic [HIST_W-1:0] spec_ghr_q, spec_ghr_d;
    logic [HIST_W-1:0] arch_ghr_q, arch_ghr_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic              resolve_err_q, resolve_err_d;

    logic [HIST_W-1:0] ckpt_mem [DEPTH];

    logic pred_ready;
    logic push;
    logic resolve_hit;
    logic mispredict;
    logic pop;

    // Ready depends only on state and occupancy so upstream can never form a loop through it.
    assign pred_ready  = (state_q == ST_RUN) && (inflight_q < CNT_W'(DEPTH));
    assign push        = bus.pred_valid && pred_ready;
    assign resolve_hit = bus.resolve_valid && (inflight_q != '0);
    assign mispredict  = resolve_hit && bus.resolve_mispredict;
    assign pop         = resolve_hit && !bus.resolve_mispredict;

    always_comb begin
        state_d       = ST_RUN;
        spec_ghr_d    = spec_ghr_q;
        arch_ghr_d    = arch_ghr_q;
        head_d        = head_q;
        tail_d        = tail_q;
        inflight_d    = inflight_q;
        resolve_err_d = bus.resolve_valid && (inflight_q == '0);

        if (mispredict) begin
            // Same-cycle push is squashed along with every younger checkpoint.
            arch_ghr_d = {arch_ghr_q[HIST_W-2:0], bus.resolve_taken};
            spec_ghr_d = {ckpt_mem[head_q][HIST_W-2:0], bus.resolve_taken};
            head_d     = tail_q;
            inflight_d = '0;
            state_d    = ST_RECOVER;
        end else begin
            if (push) begin
                spec_ghr_d = {spec_ghr_q[HIST_W-2:0], bus.pred_taken};
                tail_d     = tail_q + PTR_W'(1);
            end
            if (pop) begin
                arch_ghr_d = {arch_ghr_q[HIST_W-2:0], bus.resolve_taken};
                head_d     = head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   inflight_d = inflight_q + CNT_W'(1);
                2'b01:   inflight_d = inflight_q - CNT_W'(1);
                default: inflight_d = inflight_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            spec_ghr_q    <= '0;
            arch_ghr_q    <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            inflight_q    <= '0;
            resolve_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            spec_ghr_q    <= spec_ghr_d;
            arch_ghr_q    <= arch_ghr_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            inflight_q    <= inflight_d;
            resolve_err_q <= resolve_err_d;
        end
    end

    // Queue storage needs no reset: pointers and occupancy define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !mispredict) begin
            ckpt_mem[tail_q] <= spec_ghr_q;
        end
    end

    assign bus.pred_ready  = pred_ready;
    assign bus.spec_ghr    = spec_ghr_q;
    assign bus.arch_ghr    = arch_ghr_q;
    assign bus.inflight    = inflight_q;
    assign bus.flush       = (state_q == ST_RECOVER);
    assign bus.resolve_err = resolve_err_q;
endmodule

// File: tb/tb_ghr_checkpoint_ctrl.sv
// Directed self-checking bench for ghr_checkpoint_ctrl (HIST_W=8, DEPTH=4).
module tb_ghr_checkpoint_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    ghr_checkpoint_if #(.HIST_W(8), .DEPTH(4)) bus ();

    ghr_checkpoint_ctrl #(.HIST_W(8), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pred_valid         = 1'b0;
        bus.pred_taken         = 1'b0;
        bus.resolve_valid      = 1'b0;
        bus.resolve_taken      = 1'b0;
        bus.resolve_mispredict = 1'b0;
    endtask

    task automatic push(input logic taken);
        bus.pred_valid = 1'b1;
        bus.pred_taken = taken;
        tick();
        bus.pred_valid = 1'b0;
    endtask

    task automatic resolve(input logic taken, input logic mis);
        bus.resolve_valid      = 1'b1;
        bus.resolve_taken      = taken;
        bus.resolve_mispredict = mis;
        tick();
        bus.resolve_valid      = 1'b0;
        bus.resolve_mispredict = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        idle();

        // Reset
        do_reset();
        check("rst_spec", bus.spec_ghr, 32'h00);
        check("rst_arch", bus.arch_ghr, 32'h00);
        check("rst_inflight", bus.inflight, 32'd0);
        check("rst_ready", bus.pred_ready, 32'd1);
        check("rst_flush", bus.flush, 32'd0);
        check("rst_err", bus.resolve_err, 32'd0);

        // Fill T,N,T,T
        push(1'b1); check("fill1_spec", bus.spec_ghr, 32'h01);
        push(1'b0); check("fill2_spec", bus.spec_ghr, 32'h02);
        push(1'b1); check("fill3_spec", bus.spec_ghr, 32'h05);
        push(1'b1); check("fill4_spec", bus.spec_ghr, 32'h0B);
        check("fill_inflight", bus.inflight, 32'd4);
        check("fill_ready", bus.pred_ready, 32'd0);
        push(1'b1);
        check("full_push_spec", bus.spec_ghr, 32'h0B);
        check("full_push_inflight", bus.inflight, 32'd4);

        // Drain T,N,T,T
        resolve(1'b1, 1'b0); check("drain1_arch", bus.arch_ghr, 32'h01);
        check("drain1_inflight", bus.inflight, 32'd3);
        resolve(1'b0, 1'b0); check("drain2_arch", bus.arch_ghr, 32'h02);
        resolve(1'b1, 1'b0); check("drain3_arch", bus.arch_ghr, 32'h05);
        resolve(1'b1, 1'b0); check("drain4_arch", bus.arch_ghr, 32'h0B);
        check("drain_inflight", bus.inflight, 32'd0);
        check("drain_ready", bus.pred_ready, 32'd1);
        check("drain_spec", bus.spec_ghr, 32'h0B);
        check("drain_err", bus.resolve_err, 32'd0);

        // Mispredict from a fresh fill (head checkpoint 0x00)
        do_reset();
        push(1'b1); push(1'b0); push(1'b1); push(1'b1);
        check("refill_spec", bus.spec_ghr, 32'h0B);
        bus.pred_valid = 1'b1;
        bus.pred_taken = 1'b1;
        resolve(1'b0, 1'b1);
        check("mis_spec", bus.spec_ghr, 32'h00);
        check("mis_arch", bus.arch_ghr, 32'h00);
        check("mis_inflight", bus.inflight, 32'd0);
        check("mis_flush", bus.flush, 32'd1);
        check("mis_ready", bus.pred_ready, 32'd0);
        tick();
        bus.pred_valid = 1'b0;
        check("rec_spec_kept", bus.spec_ghr, 32'h00);
        check("rec_inflight", bus.inflight, 32'd0);
        check("post_rec_flush", bus.flush, 32'd0);
        check("post_rec_ready", bus.pred_ready, 32'd1);

        // Push accepted in the mispredict cycle is squashed
        push(1'b1);
        check("pm_pre_spec", bus.spec_ghr, 32'h01);
        bus.pred_valid = 1'b1;
        bus.pred_taken = 1'b1;
        resolve(1'b1, 1'b1);
        bus.pred_valid = 1'b0;
        check("pm_spec", bus.spec_ghr, 32'h01);
        check("pm_arch", bus.arch_ghr, 32'h01);
        check("pm_inflight", bus.inflight, 32'd0);
        check("pm_flush", bus.flush, 32'd1);
        tick();
        check("pm_flush_clear", bus.flush, 32'd0);

        // Concurrent push + correct resolve, then mispredict from advanced head
        do_reset();
        push(1'b1); push(1'b1);
        check("cc_pre_spec", bus.spec_ghr, 32'h03);
        check("cc_pre_inflight", bus.inflight, 32'd2);
        bus.pred_valid = 1'b1;
        bus.pred_taken = 1'b0;
        resolve(1'b1, 1'b0);
        bus.pred_valid = 1'b0;
        check("cc_inflight", bus.inflight, 32'd2);
        check("cc_spec", bus.spec_ghr, 32'h06);
        check("cc_arch", bus.arch_ghr, 32'h01);
        resolve(1'b0, 1'b1);
        check("cc_mis_spec", bus.spec_ghr, 32'h02);
        check("cc_mis_arch", bus.arch_ghr, 32'h02);
        tick();

        // Resolve with empty queue
        resolve(1'b1, 1'b0);
        check("err_pulse", bus.resolve_err, 32'd1);
        check("err_arch", bus.arch_ghr, 32'h02);
        check("err_spec", bus.spec_ghr, 32'h02);
        check("err_inflight", bus.inflight, 32'd0);
        tick();
        check("err_clear", bus.resolve_err, 32'd0);

        // Resolve during RECOVER is an error
        push(1'b1);
        check("r2_spec", bus.spec_ghr, 32'h05);
        resolve(1'b1, 1'b1);
        check("r2_mis_spec", bus.spec_ghr, 32'h05);
        check("r2_flush", bus.flush, 32'd1);
        resolve(1'b0, 1'b0);
        check("rec_err", bus.resolve_err, 32'd1);
        check("rec_err_arch", bus.arch_ghr, 32'h05);

        // Async reset during RECOVER
        push(1'b0);
        resolve(1'b0, 1'b1);
        check("ar_spec_pre", bus.spec_ghr, 32'h0A);
        check("ar_flush_pre", bus.flush, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_flush", bus.flush, 32'd0);
        check("ar_spec", bus.spec_ghr, 32'h00);
        check("ar_arch", bus.arch_ghr, 32'h00);
        check("ar_inflight", bus.inflight, 32'd0);
        tick();
        rst_n = 1'b1;

        // Async reset mid-stream with branches in flight
        push(1'b1); push(1'b1);
        check("ms_inflight_pre", bus.inflight, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("ms_inflight", bus.inflight, 32'd0);
        check("ms_spec", bus.spec_ghr, 32'h00);
        check("ms_ready", bus.pred_ready, 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ghr_checkpoint_ctrl.md
Name: ghr_checkpoint_ctrl

Overview:
Controller for the global history register in the branch predictor. Keeps a speculative history, updated at prediction time, and an architectural history, updated at resolve time. Holds an in-order checkpoint queue of pre-update histories, one entry per in-flight branch. On a mispredict it restores the speculative history from the oldest checkpoint, squashes all younger entries, and inserts a one-cycle recovery bubble before new predictions are accepted.

Parameters:
HIST_W, 8, history length in bits (>=2)
DEPTH, 4, max in-flight branches / checkpoint entries (power of 2, >=2)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
pred_valid  input  1  new branch predicted this cycle
pred_taken  input  1  predicted direction
pred_ready  output  1  prediction accepted when pred_valid && pred_ready
resolve_valid  input  1  oldest in-flight branch resolves this cycle
resolve_taken  input  1  actual direction
resolve_mispredict  input  1  actual != predicted; qualified by resolve_valid
spec_ghr  output  HIST_W  speculative history, used for predictor indexing
arch_ghr  output  HIST_W  committed history
inflight  output  $clog2(DEPTH)+1  checkpoint queue occupancy
flush  output  1  high for the single RECOVER cycle
resolve_err  output  1  one-cycle pulse: resolve_valid with empty queue

Behaviour:
- Reset (async, rst_n=0): spec_ghr=0, arch_ghr=0, inflight=0, queue pointers=0, state=RUN, flush=0, resolve_err=0. pred_ready=1 as soon as rst_n deasserts.
- FSM states: RUN, RECOVER.
  - RUN -> RECOVER on accepted mispredict.
  - RECOVER -> RUN unconditionally after 1 cycle.
- pred_ready = (state==RUN) && (inflight<DEPTH). Combinational from state and count only; never depends on pred_valid.
- Push (accepted prediction, RUN):
  - Write the current spec_ghr to the queue tail.
  - spec_ghr <= {spec_ghr[HIST_W-2:0], pred_taken}.
  - inflight+1.
  - Visible next cycle (1-cycle latency).
- Resolve, correct (resolve_valid, !resolve_mispredict, inflight>0):
  - Pop head.
  - arch_ghr <= {arch_ghr[HIST_W-2:0], resolve_taken}.
  - inflight-1.
  - spec_ghr unaffected.
- Resolve, mispredict (inflight>0):
  - arch_ghr <= {arch_ghr[HIST_W-2:0], resolve_taken}.
  - spec_ghr <= {head_checkpoint[HIST_W-2:0], resolve_taken}.
  - Clear queue: head=tail, inflight=0.
  - state <= RECOVER.
- RECOVER: flush=1 and pred_ready=0. A resolve in this cycle sees an empty queue and is treated as an error.
- Simultaneous push + correct resolve: both take effect; inflight unchanged; head and tail pointers both advance. Legal when full: no, because pred_ready=0 at full (no same-cycle bypass).
- Simultaneous push + mispredict: mispredict wins. The push is discarded (younger branch squashed), but it was handshaken, so upstream must treat a flush as a kill of that cycle's prediction.
- Resolve with inflight==0: no state change; resolve_err=1 for one cycle (registered, next cycle).
- Pointers are $clog2(DEPTH) bits and wrap naturally. inflight saturates logically via pred_ready; it never exceeds DEPTH or goes below 0.
- Shift arithmetic truncates to HIST_W; the oldest bit is dropped.
- rst_n asserted mid-RECOVER or mid-stream: all outputs go to reset values immediately (asynchronously) and queue contents are discarded.

Test Plan:
- Reset: hold rst_n=0 over several clocks, then release -> spec_ghr=0x00, arch_ghr=0x00, inflight=0, pred_ready=1, flush=0.
- Fill: push T,N,T,T on consecutive cycles -> spec_ghr=0x0B, inflight=4, pred_ready=0. A 5th pred_valid with taken=1 is ignored; spec_ghr stays 0x0B.
- Drain: from the fill state, 4 correct resolves with taken T,N,T,T -> arch_ghr=0x0B, inflight=0, pred_ready=1, spec_ghr still 0x0B.
- Mispredict: from the fill state (head checkpoint 0x00), resolve_mispredict with taken=0 -> next cycle spec_ghr=0x00, arch_ghr=0x00, inflight=0, flush=1, pred_ready=0. The following cycle flush=0 and pred_ready=1. A pred_valid held high during the mispredict cycle is dropped.
- Concurrent: at inflight=2 (spec=0x03), push taken=0 together with a correct resolve taken=1 -> inflight=2, spec_ghr=0x06, arch_ghr=0x01.
- Errors/reset: resolve_valid at inflight=0 -> resolve_err pulses 1 cycle, all histories unchanged. Assert rst_n=0 during the RECOVER cycle -> flush, spec_ghr and inflight go to 0 without waiting for a clock edge.
